// File: rtl/uart_parity_unit.sv
// Purpose : parity generator (TX, parallel) and serial parity checker (RX) with saturating error counter.
// Latency : tx_par_bit 1 cycle after tx_data_valid; par_done/par_err 1 cycle after the final RX strobe.
// Backpr. : none; strobe-driven, every qualified input strobe is consumed in the cycle it is seen.
//
// Ports:
//   clk, rst (async, active-low)
//   par_en, par_type      - parity config (00 even, 01 odd, 10 mark, 11 space)
//   tx_data, tx_data_valid -> tx_par_bit
//   rx_frame_start, rx_bit, rx_bit_valid, rx_par_valid -> rx_busy, par_done, par_err
//   err_cnt, err_cnt_clr  - saturating parity-error counter and its synchronous clear
module uart_parity_unit #(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     par_en,
  input  logic [1:0]               par_type,
  input  logic [DATA_WIDTH-1:0]    tx_data,
  input  logic                     tx_data_valid,
  output logic                     tx_par_bit,
  input  logic                     rx_frame_start,
  input  logic                     rx_bit,
  input  logic                     rx_bit_valid,
  input  logic                     rx_par_valid,
  output logic                     rx_busy,
  output logic                     par_done,
  output logic                     par_err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  input  logic                     err_cnt_clr
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  // Count value held before the strobe that delivers the final data bit.
  localparam logic [CNT_W-1:0]         LAST_M1 = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]         CNT_ONE = CNT_W'(1);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = ERR_CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

  // Parity bit for a given mode, where x is the XOR-reduction of the data.
  function automatic logic par_calc(input logic [1:0] t, input logic x);
    case (t)
      2'b00:   par_calc = x;
      2'b01:   par_calc = ~x;
      2'b10:   par_calc = 1'b1;
      default: par_calc = 1'b0;
    endcase
  endfunction

  state_t                   state_q, state_d;
  logic                     acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     cfg_en_q, cfg_en_d;
  logic [1:0]               cfg_type_q, cfg_type_d;
  logic                     tx_par_bit_q, tx_par_bit_d;
  logic                     rx_busy_q, rx_busy_d;
  logic                     par_done_q, par_done_d;
  logic                     par_err_q, par_err_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     exp_bit;

  always_comb begin
    tx_par_bit_d = tx_par_bit_q;
    if (!par_en) begin
      tx_par_bit_d = 1'b0;
    end else if (tx_data_valid) begin
      tx_par_bit_d = par_calc(par_type, ^tx_data);
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    cfg_en_d   = cfg_en_q;
    cfg_type_d = cfg_type_q;
    par_done_d = 1'b0;
    par_err_d  = 1'b0;
    exp_bit    = par_calc(cfg_type_q, acc_q);

    if (rx_frame_start) begin
      // A new frame always wins: any frame in flight is dropped without a pulse.
      // A data strobe in the same cycle is taken as bit 0.
      cfg_en_d   = par_en;
      cfg_type_d = par_type;
      state_d    = DATA;
      acc_d      = rx_bit_valid & rx_bit;
      cnt_d      = rx_bit_valid ? CNT_ONE : '0;
    end else begin
      case (state_q)
        DATA: begin
          if (rx_bit_valid) begin
            acc_d = acc_q ^ rx_bit;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == LAST_M1) begin
              if (cfg_en_q) begin
                state_d = PAR;
              end else begin
                state_d    = IDLE;
                par_done_d = 1'b1;
              end
            end
          end
        end
        PAR: begin
          if (rx_par_valid) begin
            par_done_d = 1'b1;
            par_err_d  = (rx_bit != exp_bit);
            state_d    = IDLE;
          end
        end
        default: ;
      endcase
    end

    rx_busy_d = (state_d != IDLE);
  end

  // Counter follows the registered par_err pulse; clear has priority.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (par_err_q && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      cfg_en_q     <= 1'b0;
      cfg_type_q   <= 2'b00;
      tx_par_bit_q <= 1'b0;
      rx_busy_q    <= 1'b0;
      par_done_q   <= 1'b0;
      par_err_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      cfg_en_q     <= cfg_en_d;
      cfg_type_q   <= cfg_type_d;
      tx_par_bit_q <= tx_par_bit_d;
      rx_busy_q    <= rx_busy_d;
      par_done_q   <= par_done_d;
      par_err_q    <= par_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign tx_par_bit = tx_par_bit_q;
  assign rx_busy    = rx_busy_q;
  assign par_done   = par_done_q;
  assign par_err    = par_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_parity_unit.sv
// Bench for uart_parity_unit: u0 (8 data bits, 8-bit counter), u1 (5 data bits), u2 (8 data bits, 2-bit counter).
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// RX results go through a scoreboard queue checked by a par_done monitor.
module tb_uart_parity_unit;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       par_en;
  logic [1:0] par_type;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       rx_bit;
  logic [2:0] fs, bv, pv;
  logic       err_cnt_clr;

  logic [2:0] txp_w, busy_w, done_w, err_w;
  logic [7:0] ec0, ec1;
  logic [1:0] ec2;

  int checks = 0;
  int errors = 0;
  int done_cnt [3];

  typedef struct {
    int   inst;
    logic err;
  } exp_t;
  exp_t sb_q[$];
  logic tx_q[$];

  uart_parity_unit #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8)) u0 (
    .clk(clk), .rst(rst), .par_en(par_en), .par_type(par_type),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_par_bit(txp_w[0]),
    .rx_frame_start(fs[0]), .rx_bit(rx_bit), .rx_bit_valid(bv[0]), .rx_par_valid(pv[0]),
    .rx_busy(busy_w[0]), .par_done(done_w[0]), .par_err(err_w[0]),
    .err_cnt(ec0), .err_cnt_clr(err_cnt_clr));

  uart_parity_unit #(.DATA_WIDTH(5), .ERR_CNT_WIDTH(8)) u1 (
    .clk(clk), .rst(rst), .par_en(par_en), .par_type(par_type),
    .tx_data(tx_data[4:0]), .tx_data_valid(1'b0), .tx_par_bit(txp_w[1]),
    .rx_frame_start(fs[1]), .rx_bit(rx_bit), .rx_bit_valid(bv[1]), .rx_par_valid(pv[1]),
    .rx_busy(busy_w[1]), .par_done(done_w[1]), .par_err(err_w[1]),
    .err_cnt(ec1), .err_cnt_clr(err_cnt_clr));

  uart_parity_unit #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .par_en(par_en), .par_type(par_type),
    .tx_data(tx_data), .tx_data_valid(1'b0), .tx_par_bit(txp_w[2]),
    .rx_frame_start(fs[2]), .rx_bit(rx_bit), .rx_bit_valid(bv[2]), .rx_par_valid(pv[2]),
    .rx_busy(busy_w[2]), .par_done(done_w[2]), .par_err(err_w[2]),
    .err_cnt(ec2), .err_cnt_clr(err_cnt_clr));

  // Scoreboard monitor: every par_done must match the oldest expected frame result.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_w[i] === 1'b1) begin
        exp_t e;
        done_cnt[i]++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_done: inst %0d par_done=1 par_err=%b, no frame expected", i, err_w[i]);
        end else begin
          e = sb_q.pop_front();
          if (e.inst != i || err_w[i] !== e.err) begin
            errors++;
            $display("FAIL sb_frame: inst %0d par_err=%b, expected inst %0d par_err=%b", i, err_w[i], e.inst, e.err);
          end
        end
      end else if (err_w[i] === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL sb_err_without_done: inst %0d par_err=1 par_done=%b", i, done_w[i]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tx_step(input logic en, input logic [1:0] t, input logic [7:0] d,
                         input logic v, input logic exp, input string name);
    logic e;
    par_en = en; par_type = t; tx_data = d; tx_data_valid = v;
    tx_q.push_back(exp);
    @(negedge clk);
    tx_data_valid = 1'b0;
    e = tx_q.pop_front();
    checks++;
    if (txp_w[0] !== e) begin
      errors++;
      $display("FAIL %s: tx_par_bit=%b expected %b", name, txp_w[0], e);
    end
  endtask

  task automatic rx_start(input int i, input logic en, input logic [1:0] t);
    par_en = en; par_type = t; fs[i] = 1'b1;
    @(negedge clk);
    fs[i] = 1'b0;
  endtask

  task automatic rx_bits(input int i, input logic [7:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      rx_bit = d[k]; bv[i] = 1'b1;
      @(negedge clk);
      bv[i] = 1'b0;
    end
  endtask

  task automatic rx_par(input int i, input logic b, input logic exp_err, input string name);
    exp_t e;
    e.inst = i; e.err = exp_err;
    sb_q.push_back(e);
    rx_bit = b; pv[i] = 1'b1;
    @(negedge clk);
    pv[i] = 1'b0;
    checks++;
    if (done_w[i] !== 1'b1 || err_w[i] !== exp_err) begin
      errors++;
      $display("FAIL %s: par_done=%b par_err=%b expected 1 %b", name, done_w[i], err_w[i], exp_err);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 20 && sb_q.size() != 0; c++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected frames never completed, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic bad_frame(input int i, input string name);
    rx_start(i, 1'b1, 2'b01);
    rx_bits(i, 8'hA5, 8);
    rx_par(i, 1'b0, 1'b1, name);
    wait_drain(name);
  endtask

  task automatic test_reset();
    rst = 1'b0; par_en = 1'b0; par_type = 2'b00; tx_data = '0; tx_data_valid = 1'b0;
    rx_bit = 1'b0; fs = '0; bv = '0; pv = '0; err_cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({txp_w, busy_w, done_w, err_w} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: tx/busy/done/err=%h expected 000", {txp_w, busy_w, done_w, err_w});
    end
    checks++;
    if (ec0 !== 8'd0 || ec1 !== 8'd0 || ec2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_err_cnt: %0d %0d %0d expected 0 0 0", ec0, ec1, ec2);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tx();
    tx_step(1'b1, 2'b00, 8'hA5, 1'b1, 1'b0, "tx_even_a5");
    tx_step(1'b1, 2'b00, 8'h07, 1'b1, 1'b1, "tx_even_07");
    tx_step(1'b1, 2'b01, 8'h07, 1'b1, 1'b0, "tx_odd_07");
    tx_step(1'b1, 2'b10, 8'h07, 1'b1, 1'b1, "tx_mark");
    tx_step(1'b1, 2'b11, 8'h07, 1'b1, 1'b0, "tx_space");
    tx_step(1'b1, 2'b10, 8'h00, 1'b1, 1'b1, "tx_mark_again");
    tx_step(1'b1, 2'b00, 8'hA5, 1'b0, 1'b1, "tx_hold_no_valid");
    tx_step(1'b0, 2'b10, 8'h07, 1'b1, 1'b0, "tx_disabled");
  endtask

  task automatic test_rx_good();
    rx_start(0, 1'b1, 2'b00);
    checks++;
    if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL good_busy_start: rx_busy=%b expected 1", busy_w[0]); end
    rx_bits(0, 8'h07, 8);
    checks++;
    if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL good_busy_par: rx_busy=%b expected 1", busy_w[0]); end
    rx_par(0, 1'b1, 1'b0, "good_frame");
    checks++;
    if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL good_busy_done: rx_busy=%b expected 0", busy_w[0]); end
    wait_drain("good_drain");
    @(negedge clk);
    checks++;
    if (ec0 !== 8'd0) begin errors++; $display("FAIL good_err_cnt: err_cnt=%0d expected 0", ec0); end
  endtask

  task automatic test_rx_bad();
    bad_frame(0, "bad_frame1");
    @(negedge clk);
    checks++;
    if (ec0 !== 8'd1) begin errors++; $display("FAIL bad_err_cnt1: err_cnt=%0d expected 1", ec0); end
    bad_frame(0, "bad_frame2");
    @(negedge clk);
    checks++;
    if (ec0 !== 8'd2) begin errors++; $display("FAIL bad_err_cnt2: err_cnt=%0d expected 2", ec0); end
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt[0];
    rx_start(0, 1'b1, 2'b00);
    rx_bits(0, 8'h0F, 4);
    par_type = 2'b01;
    @(negedge clk);
    rx_start(0, 1'b1, 2'b01);
    rx_bits(0, 8'h07, 4);
    // Config churn mid-frame must not touch the latched odd/enabled setting.
    par_type = 2'b00; par_en = 1'b0;
    rx_bits(0, 8'h00, 4);
    rx_par(0, 1'b0, 1'b0, "abort_odd_frame");
    wait_drain("abort_drain");
    checks++;
    if (done_cnt[0] - d0 != 1) begin errors++; $display("FAIL abort_done_count: %0d pulses expected 1", done_cnt[0] - d0); end
    checks++;
    if (ec0 !== 8'd2) begin errors++; $display("FAIL abort_err_cnt: err_cnt=%0d expected 2", ec0); end
  endtask

  task automatic test_disabled();
    int d1;
    exp_t e;
    d1 = done_cnt[1];
    rx_start(1, 1'b0, 2'b00);
    rx_bits(1, 8'h16, 4);
    e.inst = 1; e.err = 1'b0;
    sb_q.push_back(e);
    rx_bits(1, 8'h01, 1);
    checks++;
    if (done_w[1] !== 1'b1 || err_w[1] !== 1'b0 || busy_w[1] !== 1'b0) begin
      errors++;
      $display("FAIL dis_done: done=%b err=%b busy=%b expected 1 0 0", done_w[1], err_w[1], busy_w[1]);
    end
    par_en = 1'b1;
    rx_bit = 1'b1; pv[1] = 1'b1;
    @(negedge clk);
    pv[1] = 1'b0;
    repeat (3) @(negedge clk);
    wait_drain("dis_drain");
    checks++;
    if (done_cnt[1] - d1 != 1) begin errors++; $display("FAIL dis_done_count: %0d pulses expected 1", done_cnt[1] - d1); end
  endtask

  task automatic test_counter();
    for (int f = 0; f < 4; f++) bad_frame(2, "sat_frame");
    @(negedge clk);
    checks++;
    if (ec2 !== 2'd3) begin errors++; $display("FAIL sat_err_cnt: err_cnt=%0d expected 3", ec2); end
    rx_start(2, 1'b1, 2'b01);
    rx_bits(2, 8'hA5, 8);
    rx_par(2, 1'b0, 1'b1, "clr_frame");
    err_cnt_clr = 1'b1;
    @(negedge clk);
    err_cnt_clr = 1'b0;
    checks++;
    if (ec2 !== 2'd0) begin errors++; $display("FAIL clr_coincident: err_cnt=%0d expected 0", ec2); end
    wait_drain("clr_drain");
  endtask

  task automatic test_reset_mid();
    int dsum;
    bad_frame(2, "pre_reset_frame");
    @(negedge clk);
    checks++;
    if (ec2 !== 2'd1) begin errors++; $display("FAIL pre_reset_err_cnt: err_cnt=%0d expected 1", ec2); end
    tx_step(1'b1, 2'b10, 8'h00, 1'b1, 1'b1, "pre_reset_tx");
    rx_start(0, 1'b1, 2'b00);
    rx_bits(0, 8'h07, 3);
    checks++;
    if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: rx_busy=%b expected 1", busy_w[0]); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({txp_w, busy_w, done_w, err_w} !== 12'h000 || ec0 !== 8'd0 || ec2 !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset: tx/busy/done/err=%h ec0=%0d ec2=%0d expected 000 0 0",
               {txp_w, busy_w, done_w, err_w}, ec0, ec2);
    end
    @(negedge clk);
    rst = 1'b1;
    dsum = done_cnt[0] + done_cnt[1] + done_cnt[2];
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt[0] + done_cnt[1] + done_cnt[2] != dsum || busy_w !== 3'b000) begin
      errors++;
      $display("FAIL post_reset: extra pulses=%0d busy=%b expected 0 000",
               done_cnt[0] + done_cnt[1] + done_cnt[2] - dsum, busy_w);
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx_good();
    test_rx_bad();
    test_abort();
    test_disabled();
    test_counter();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
